// File: rtl/prince_inv_sbox_cms_if.sv
// Handshake bundle for the masked PRINCE inverse S-box: share-packed input
// nibble plus fresh masks in, share-packed result out.
interface prince_inv_sbox_cms_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_sh;
  logic [11:0] rnd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y_sh;

  modport master (
    output in_valid, x_sh, rnd, out_ready,
    input  in_ready, out_valid, y_sh
  );

  modport slave (
    input  in_valid, x_sh, rnd, out_ready,
    output in_ready, out_valid, y_sh
  );
endinterface

// File: rtl/prince_inv_sbox_cms.sv
// 4-share first-order masked PRINCE inverse S-box: non-complete cubic direct
// sharing, fresh-mask refresh, then a registered glitch barrier with valid/ready.
module prince_inv_sbox_cms (
  input  logic                  clk,
  input  logic                  rst,
  prince_inv_sbox_cms_if.slave  bus
);
  localparam int unsigned RND_W = 12;

  // S^-1 table, entry i at bits [4i+3:4i]
  localparam logic [63:0] SINV_LUT = 64'h1CE5_046A_98DF_237B;

  // Moebius transform of one output bit: coefficient of monomial m at bit m.
  function automatic logic [15:0] anf_of(input int unsigned b);
    logic [15:0] a;
    a = '0;
    for (int unsigned m = 0; m < 16; m++) a[4'(m)] = SINV_LUT[6'(4*m + b)];
    for (int unsigned i = 0; i < 4; i++)
      for (int unsigned m = 0; m < 16; m++)
        if (((m >> i) & 1) != 0) a[4'(m)] = a[4'(m)] ^ a[4'(m ^ (1 << i))];
    return a;
  endfunction

  localparam logic [63:0] ANF = {anf_of(3), anf_of(2), anf_of(1), anf_of(0)};

  // Direct sharing: every cross-share term of a monomial uses at most three
  // share indices and goes to the lowest output share index it does not touch,
  // so component j never reads input share j and the components XOR to S^-1.
  function automatic logic [3:0] component(input int unsigned j, input logic [15:0] x);
    logic [3:0]  c;
    logic [7:0]  sel;
    logic [3:0]  used;
    logic        t;
    logic        found;
    int unsigned idx;
    int unsigned own;
    c = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      for (int unsigned m = 0; m < 16; m++) begin
        if (ANF[6'(16*b + m)]) begin
          sel = '0;
          for (int unsigned v = 0; v < 4; v++)
            if (((m >> v) & 1) != 0) sel = sel | 8'(3 << (2*v));
          for (int unsigned code = 0; code < 256; code++) begin
            if ((8'(code) & ~sel) != '0) continue;
            t    = 1'b1;
            used = '0;
            for (int unsigned v = 0; v < 4; v++) begin
              if (((m >> v) & 1) != 0) begin
                idx = (code >> (2*v)) & 3;
                t = t & x[4'(4*idx + v)];
                used[2'(idx)] = 1'b1;
              end
            end
            own   = 0;
            found = 1'b0;
            for (int unsigned k = 0; k < 4; k++) begin
              if (!found && !used[2'(k)]) begin
                own   = k;
                found = 1'b1;
              end
            end
            if (own == j) c[2'(b)] = c[2'(b)] ^ t;
          end
        end
      end
    end
    return c;
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [15:0]      y_sh_q, y_sh_d;
  logic             in_ready;
  logic             take_in;
  logic             take_out;
  logic [15:0]      c_sh;
  logic [15:0]      y_ref;
  logic [RND_W-1:0] r;

  always_comb begin
    in_ready = !out_valid_q || bus.out_ready;
    take_in  = bus.in_valid && in_ready;
    take_out = out_valid_q && bus.out_ready;
    r        = bus.rnd;

    c_sh = '0;
    for (int unsigned j = 0; j < 4; j++)
      c_sh[4*j +: 4] = component(j, bus.x_sh & ~(16'(4'hF) << (4*j)));

    y_ref = {c_sh[15:12] ^ r[3:0] ^ r[7:4] ^ r[11:8],
             c_sh[11:8]  ^ r[11:8],
             c_sh[7:4]   ^ r[7:4],
             c_sh[3:0]   ^ r[3:0]};

    out_valid_d = out_valid_q;
    y_sh_d      = y_sh_q;
    if (take_in) begin
      y_sh_d      = y_ref;
      out_valid_d = 1'b1;
    end else if (take_out) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_sh_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      y_sh_q      <= y_sh_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y_sh      = y_sh_q;
endmodule

// File: tb/tb_prince_inv_sbox_cms.sv
// Directed and table-driven check of the masked PRINCE inverse S-box.
module tb_prince_inv_sbox_cms;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prince_inv_sbox_cms_if bus ();

  prince_inv_sbox_cms dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [3:0] sinv [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                           4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};

  typedef struct {
    logic [15:0] x;
    logic [11:0] r;
    logic [3:0]  exp;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [3:0] xs(input logic [15:0] v);
    return v[3:0] ^ v[7:4] ^ v[11:8] ^ v[15:12];
  endfunction

  function automatic logic [15:0] split(input logic [3:0] n);
    logic [3:0] s0, s1, s2;
    s0 = 4'($urandom);
    s1 = 4'($urandom);
    s2 = 4'($urandom);
    return {n ^ s0 ^ s1 ^ s2, s2, s1, s0};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] x, input logic [11:0] r,
                       input logic ordy);
    bus.in_valid  = v;
    bus.x_sh      = x;
    bus.rnd       = r;
    bus.out_ready = ordy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held, ybase, ya, x2, x;
    logic [11:0] r;
    logic [11:0] rv [3];
    logic [3:0]  d;

    tbl[0] = '{16'h000A, 12'h000, 4'h4};
    tbl[1] = '{16'h5F00, 12'h000, 4'h4};
    tbl[2] = '{16'h0000, 12'h5A3, 4'hB};
    tbl[3] = '{16'h1234, 12'hFFF, 4'hF};
    tbl[4] = '{16'hFFFF, 12'h123, 4'hB};
    tbl[5] = '{16'h000F, 12'h000, 4'h1};
    tbl[6] = '{16'h8421, 12'h777, 4'h1};
    tbl[7] = '{16'hC000, 12'h000, 4'h5};
    tbl[8] = '{16'h0030, 12'h0AB, 4'h2};
    rv[0] = 12'h000; rv[1] = 12'hFFF; rv[2] = 12'h5A3;

    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    tick; tick;
    chk("rst_out_valid", 16'(bus.out_valid), 16'h0);
    chk("rst_y_sh", bus.y_sh, 16'h0);
    chk("rst_in_ready", 16'(bus.in_ready), 16'h1);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(1'b1, tbl[i].x, tbl[i].r, 1'b1);
      tick;
      chk("tbl_out_valid", 16'(bus.out_valid), 16'h1);
      chk($sformatf("tbl%0d_xor", i), 16'(xs(bus.y_sh)), 16'(tbl[i].exp));
    end

    // Back-to-back stream, one result per cycle.
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 8; k++) begin
        drive(1'b1, split(4'(n)), 12'($urandom), 1'b1);
        tick;
        chk("stream_out_valid", 16'(bus.out_valid), 16'h1);
        chk($sformatf("stream_n%0d_xor", n), 16'(xs(bus.y_sh)), 16'(sinv[n]));
      end
    end
    drive(1'b0, '0, '0, 1'b1);
    tick;
    chk("drain_out_valid", 16'(bus.out_valid), 16'h0);

    // Backpressure: 2 accepted, 5 stalls, then 5 and C flow while 3 and D drain.
    drive(1'b1, split(4'h2), 12'($urandom), 1'b0);
    tick;
    chk("bp_first_valid", 16'(bus.out_valid), 16'h1);
    chk("bp_first_xor", 16'(xs(bus.y_sh)), 16'h3);
    held = bus.y_sh;
    drive(1'b1, split(4'h5), 12'($urandom), 1'b0);
    for (int s = 0; s < 3; s++) begin
      chk("bp_stall_in_ready", 16'(bus.in_ready), 16'h0);
      bus.rnd = 12'($urandom);
      tick;
      chk("bp_stall_valid", 16'(bus.out_valid), 16'h1);
      chk("bp_stall_y_stable", bus.y_sh, held);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 16'(bus.in_ready), 16'h1);
    tick;
    chk("bp_second_valid", 16'(bus.out_valid), 16'h1);
    chk("bp_second_xor", 16'(xs(bus.y_sh)), 16'hD);
    drive(1'b1, split(4'hC), 12'($urandom), 1'b1);
    tick;
    chk("bp_third_xor", 16'(xs(bus.y_sh)), 16'h5);
    drive(1'b0, '0, '0, 1'b1);
    tick;
    chk("bp_empty_valid", 16'(bus.out_valid), 16'h0);

    // Idle with garbage inputs must not disturb the registers.
    held = bus.y_sh;
    for (int s = 0; s < 3; s++) begin
      drive(1'b0, 16'($urandom), 12'($urandom), 1'($urandom));
      tick;
      chk("idle_valid", 16'(bus.out_valid), 16'h0);
      chk("idle_y_hold", bus.y_sh, held);
    end

    // Refresh: sharing changes by exactly the mask pattern, XOR constant.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h37C1, rv[i], 1'b1);
      tick;
      chk("refresh_xor", 16'(xs(bus.y_sh)), 16'h6);
      if (i == 0) ybase = bus.y_sh;
      else chk($sformatf("refresh_diff%0d", i), bus.y_sh ^ ybase,
               {rv[i][3:0] ^ rv[i][7:4] ^ rv[i][11:8], rv[i][11:8], rv[i][7:4], rv[i][3:0]});
    end

    // Non-completeness: toggling input share j leaves output share j unchanged.
    for (int j = 0; j < 4; j++) begin
      for (int t = 0; t < 3; t++) begin
        x = 16'($urandom);
        r = 12'($urandom);
        drive(1'b1, x, r, 1'b1);
        tick;
        ya = bus.y_sh;
        d  = 4'($urandom_range(1, 15));
        x2 = x ^ (16'(d) << (4*j));
        drive(1'b1, x2, r, 1'b1);
        tick;
        chk($sformatf("noncomp_share%0d", j), 16'((bus.y_sh >> (4*j)) & 16'hF),
            16'((ya >> (4*j)) & 16'hF));
        chk("noncomp_xor", 16'(xs(bus.y_sh)), 16'(sinv[xs(x2)]));
      end
    end

    // Reset beats a simultaneous transfer and drops the held result.
    drive(1'b1, split(4'h7), 12'($urandom), 1'b0);
    tick;
    chk("rstmid_pre_valid", 16'(bus.out_valid), 16'h1);
    rst = 1'b1;
    drive(1'b1, split(4'h9), 12'($urandom), 1'b1);
    tick;
    chk("rstmid_valid", 16'(bus.out_valid), 16'h0);
    chk("rstmid_y_sh", bus.y_sh, 16'h0);
    chk("rstmid_in_ready", 16'(bus.in_ready), 16'h1);
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    tick;
    chk("rstmid_dropped_valid", 16'(bus.out_valid), 16'h0);
    chk("rstmid_dropped_y", bus.y_sh, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
